// File: rtl/loop_filter_gearshift_pkg.sv
// Shared definitions for the gear-shifting PI loop filter.
// - gear_e      : gear encoding carried on gear_o (0=ACQ, 1=TRACK, 2=LOCKED)
// - CALC_W      : working width of the filter datapath (wide enough for every product and sum)
// - sat_max/min : signed range limits for a given width
// - sat_signed  : clip a working-width value into a narrower signed range
// - abs_clip    : magnitude with the most negative code folded onto the most positive one
package loop_filter_gearshift_pkg;

    typedef enum logic [1:0] {
        GEAR_ACQ = 2'd0,
        GEAR_TRK = 2'd1,
        GEAR_LCK = 2'd2
    } gear_e;

    localparam int unsigned CALC_W = 32;

    function automatic logic signed [CALC_W-1:0] sat_max(input int unsigned w);
        logic signed [CALC_W-1:0] one;
        one = 1;
        return (one <<< (w - 1)) - one;
    endfunction

    function automatic logic signed [CALC_W-1:0] sat_min(input int unsigned w);
        logic signed [CALC_W-1:0] one;
        one = 1;
        return -(one <<< (w - 1));
    endfunction

    function automatic logic signed [CALC_W-1:0] sat_signed(input logic signed [CALC_W-1:0] v,
                                                            input int unsigned w);
        if (v > sat_max(w)) return sat_max(w);
        if (v < sat_min(w)) return sat_min(w);
        return v;
    endfunction

    // -2^(w-1) has no positive counterpart in w bits, so it reads as 2^(w-1)-1.
    function automatic logic [CALC_W-1:0] abs_clip(input logic signed [CALC_W-1:0] v,
                                                  input int unsigned w);
        if (v <= sat_min(w)) return CALC_W'(sat_max(w));
        if (v < 0) return CALC_W'(-v);
        return CALC_W'(v);
    endfunction

endpackage

// File: rtl/loop_filter_gearshift_lock_detector.sv
// Lock detector and gear FSM for the loop filter.
// Counts consecutive settled samples to step ACQ -> TRACK -> LOCKED and consecutive slips to
// fall back to ACQ. Advances only on cycles where update_i is high.
// Ports:
// - gen_clk_i, reset_i : clock, asynchronous active-high reset
// - update_i           : a filter update happens this cycle
// - error_i            : signed phase error
// - gear_o             : current gear (registered)
// - lock_o             : high iff gear_o is LOCKED
module loop_filter_gearshift_lock_detector
    import loop_filter_gearshift_pkg::*;
#(
    parameter int unsigned ERROR_WIDTH   = 8,
    parameter int unsigned LOCK_THRESH   = 2,
    parameter int unsigned LOCK_COUNT    = 16,
    parameter int unsigned UNLOCK_THRESH = 8,
    parameter int unsigned UNLOCK_COUNT  = 4
) (
    input  logic                          gen_clk_i,
    input  logic                          reset_i,
    input  logic                          update_i,
    input  logic signed [ERROR_WIDTH-1:0] error_i,
    output gear_e                         gear_o,
    output logic                          lock_o
);

    localparam int unsigned LOCK_CNT_W = $clog2(LOCK_COUNT + 1);
    localparam int unsigned SLIP_CNT_W = $clog2(UNLOCK_COUNT + 1);

    gear_e                  gear_q, gear_d;
    logic [LOCK_CNT_W-1:0]  lock_cnt_q, lock_cnt_d;
    logic [SLIP_CNT_W-1:0]  slip_cnt_q, slip_cnt_d;
    logic [CALC_W-1:0]      err_mag;
    logic                   settled;
    logic                   slip;

    always_comb begin
        err_mag = abs_clip(CALC_W'(error_i), ERROR_WIDTH);
        settled = (err_mag <= CALC_W'(LOCK_THRESH));
        slip    = (err_mag > CALC_W'(UNLOCK_THRESH));
    end

    always_ff @(posedge gen_clk_i or posedge reset_i) begin
        if (reset_i) begin
            gear_q     <= GEAR_ACQ;
            lock_cnt_q <= '0;
            slip_cnt_q <= '0;
        end else begin
            gear_q     <= gear_d;
            lock_cnt_q <= lock_cnt_d;
            slip_cnt_q <= slip_cnt_d;
        end
    end

    always_comb begin
        gear_d     = gear_q;
        lock_cnt_d = lock_cnt_q;
        slip_cnt_d = slip_cnt_q;
        if (update_i) begin
            unique case (gear_q)
                GEAR_ACQ, GEAR_TRK: begin
                    if ((gear_q == GEAR_TRK) && slip) begin
                        gear_d     = GEAR_ACQ;
                        lock_cnt_d = '0;
                    end else if (settled) begin
                        if (lock_cnt_q == LOCK_CNT_W'(LOCK_COUNT - 1)) begin
                            gear_d     = (gear_q == GEAR_ACQ) ? GEAR_TRK : GEAR_LCK;
                            lock_cnt_d = '0;
                        end else begin
                            lock_cnt_d = lock_cnt_q + LOCK_CNT_W'(1);
                        end
                    end else begin
                        lock_cnt_d = '0;
                    end
                end
                GEAR_LCK: begin
                    if (slip) begin
                        if (slip_cnt_q == SLIP_CNT_W'(UNLOCK_COUNT - 1)) begin
                            gear_d     = GEAR_ACQ;
                            lock_cnt_d = '0;
                            slip_cnt_d = '0;
                        end else begin
                            slip_cnt_d = slip_cnt_q + SLIP_CNT_W'(1);
                        end
                    end else begin
                        slip_cnt_d = '0;
                    end
                end
                default: begin
                    gear_d     = GEAR_ACQ;
                    lock_cnt_d = '0;
                    slip_cnt_d = '0;
                end
            endcase
        end
    end

    always_comb begin
        gear_o = gear_q;
        lock_o = (gear_q == GEAR_LCK);
    end

endmodule

// File: rtl/loop_filter_gearshift.sv
// Gear-shifting PI loop filter for the ADPLL: TDC phase error in, DCO control code out.
// Gains are selected by the registered gear, so an update on a gear-change edge still uses
// the old gear's gains. The integrator saturates to its own range and is held (anti-windup)
// when the output clips in the direction the integral term is pushing.
// Ports:
// - gen_clk_i, reset_i            : clock, asynchronous active-high reset
// - error_valid_i, error_i        : signed phase error and its qualifier
// - kp_*_i / ki_*_i               : per-gear unsigned fixed-point gains
// - freeze_i                      : open-loop hold of integrator, FSM and output
// - dco_cc_o                      : registered signed DCO control code
// - gear_o, lock_o                : current gear, lock indication
// - sat_o                         : output was clipped on the last update
module loop_filter_gearshift
    import loop_filter_gearshift_pkg::*;
#(
    parameter int unsigned ERROR_WIDTH   = 8,
    parameter int unsigned DCO_CC_WIDTH  = 9,
    parameter int unsigned KP_WIDTH      = 4,
    parameter int unsigned KP_FRAC_WIDTH = 1,
    parameter int unsigned KI_WIDTH      = 6,
    parameter int unsigned KI_FRAC_WIDTH = 4,
    parameter int unsigned ACC_INT_WIDTH = 12,
    parameter int unsigned LOCK_THRESH   = 2,
    parameter int unsigned LOCK_COUNT    = 16,
    parameter int unsigned UNLOCK_THRESH = 8,
    parameter int unsigned UNLOCK_COUNT  = 4
) (
    input  logic                           gen_clk_i,
    input  logic                           reset_i,
    input  logic                           error_valid_i,
    input  logic signed [ERROR_WIDTH-1:0]  error_i,
    input  logic [KP_WIDTH-1:0]            kp_acq_i,
    input  logic [KP_WIDTH-1:0]            kp_trk_i,
    input  logic [KP_WIDTH-1:0]            kp_lck_i,
    input  logic [KI_WIDTH-1:0]            ki_acq_i,
    input  logic [KI_WIDTH-1:0]            ki_trk_i,
    input  logic [KI_WIDTH-1:0]            ki_lck_i,
    input  logic                           freeze_i,
    output logic signed [DCO_CC_WIDTH-1:0] dco_cc_o,
    output logic [1:0]                     gear_o,
    output logic                           lock_o,
    output logic                           sat_o
);

    localparam int unsigned ACC_WIDTH  = ACC_INT_WIDTH + KI_FRAC_WIDTH;
    // Aligns the proportional term's binary point with the integrator's.
    localparam int unsigned FRAC_ALIGN = KI_FRAC_WIDTH - KP_FRAC_WIDTH;

    gear_e                          gear;
    logic                           lock;
    logic                           update;
    logic [KP_WIDTH-1:0]            kp_sel;
    logic [KI_WIDTH-1:0]            ki_sel;
    logic signed [CALC_W-1:0]       err_w, kp_w, ki_w, p_w, i_w;
    logic signed [CALC_W-1:0]       acc_c, sum_w, dco_full, dco_sat;
    logic                           clip_hi, clip_lo, hold_acc;
    logic signed [ACC_WIDTH-1:0]    acc_q, acc_d;
    logic signed [DCO_CC_WIDTH-1:0] dco_q, dco_d;
    logic                           sat_q, sat_d;

    assign update = error_valid_i & ~freeze_i;

    loop_filter_gearshift_lock_detector #(
        .ERROR_WIDTH   (ERROR_WIDTH),
        .LOCK_THRESH   (LOCK_THRESH),
        .LOCK_COUNT    (LOCK_COUNT),
        .UNLOCK_THRESH (UNLOCK_THRESH),
        .UNLOCK_COUNT  (UNLOCK_COUNT)
    ) u_lock_detector (
        .gen_clk_i (gen_clk_i),
        .reset_i   (reset_i),
        .update_i  (update),
        .error_i   (error_i),
        .gear_o    (gear),
        .lock_o    (lock)
    );

    always_comb begin
        kp_sel = kp_acq_i;
        ki_sel = ki_acq_i;
        unique case (gear)
            GEAR_TRK: begin
                kp_sel = kp_trk_i;
                ki_sel = ki_trk_i;
            end
            GEAR_LCK: begin
                kp_sel = kp_lck_i;
                ki_sel = ki_lck_i;
            end
            default: begin
                kp_sel = kp_acq_i;
                ki_sel = ki_acq_i;
            end
        endcase
    end

    always_comb begin
        err_w    = CALC_W'(error_i);
        kp_w     = CALC_W'(kp_sel);
        ki_w     = CALC_W'(ki_sel);
        p_w      = (err_w * kp_w) <<< FRAC_ALIGN;
        i_w      = err_w * ki_w;
        acc_c    = sat_signed(CALC_W'(acc_q) + i_w, ACC_WIDTH);
        sum_w    = p_w + acc_c;
        // Arithmetic shift gives floor for negative sums.
        dco_full = sum_w >>> KI_FRAC_WIDTH;
        dco_sat  = sat_signed(dco_full, DCO_CC_WIDTH);
        clip_hi  = (dco_full > sat_max(DCO_CC_WIDTH));
        clip_lo  = (dco_full < sat_min(DCO_CC_WIDTH));
        hold_acc = (clip_hi && (i_w > 0)) || (clip_lo && (i_w < 0));
        acc_d    = hold_acc ? acc_q : ACC_WIDTH'(acc_c);
        dco_d    = DCO_CC_WIDTH'(dco_sat);
        sat_d    = clip_hi | clip_lo;
    end

    always_ff @(posedge gen_clk_i or posedge reset_i) begin
        if (reset_i) begin
            acc_q <= '0;
            dco_q <= '0;
            sat_q <= 1'b0;
        end else if (update) begin
            acc_q <= acc_d;
            dco_q <= dco_d;
            sat_q <= sat_d;
        end
    end

    assign dco_cc_o = dco_q;
    assign sat_o    = sat_q;
    assign gear_o   = gear;
    assign lock_o   = lock;

endmodule
